// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: FSM encoding, counter
// constants and PC field extraction.
package bp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bp_state_e;

  localparam int IDX_W_DEF  = 6;
  localparam int CNT_W_DEF  = 2;
  localparam int TAG_W_DEF  = 8;
  localparam int STAT_W_DEF = 16;

  // Weakly not-taken starting value and saturation ceiling for a cnt_w-bit counter.
  function automatic int unsigned cnt_init(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  function automatic logic [31:0] idx(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag(input logic [31:0] pc, input int unsigned idx_w,
                                      input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-update bus between the CPU pipeline and the predictor.
interface branch_predictor_if #(
  parameter int STAT_W = 16
);
  logic              flush;
  logic [31:0]       if_pc;
  logic              pred_taken;
  logic              pred_hit;
  logic [31:0]       pred_target;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_pred_taken;
  logic              ready;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output flush, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    input  pred_taken, pred_hit, pred_target, ready, stat_branches, stat_mispred
  );

  modport slave (
    input  flush, if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    output pred_taken, pred_hit, pred_target, ready, stat_branches, stat_mispred
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Next-value logic for one CNT_W-bit saturating counter (increment, decrement or hold).
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i && (cnt_i != CNT_MAX)) begin
      cnt_o = cnt_i + 1'b1;
    end else if (dec_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: table of saturating counters with a clearing FSM and stats.
// Define BP_BTB_EN to add a tagged branch-target buffer alongside each counter.
//
// state    | meaning
// ST_CLEAR | walking clr_idx over the table, writing weakly not-taken; no predictions
// ST_RUN   | table valid; zero-latency lookups, updates applied on the clock edge
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  branch_predictor_if.slave   bus
);

  localparam int               ENTRIES  = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  bp_state_e          state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [STAT_W-1:0]  stat_br_q, stat_br_d;
  logic [STAT_W-1:0]  stat_mp_q, stat_mp_d;
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_d [ENTRIES];

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [CNT_W-1:0]   lk_cnt, up_cnt_nxt;
  logic               ready;

  assign lk_idx = IDX_W'(idx(bus.if_pc, IDX_W));
  assign up_idx = IDX_W'(idx(bus.upd_pc, IDX_W));
  assign lk_cnt = cnt_q[lk_idx];
  assign ready  = (state_q == ST_RUN);

  bp_sat_counter #(.CNT_W(CNT_W)) u_upd_cnt (
    .cnt_i (cnt_q[up_idx]),
    .inc_i (bus.upd_taken),
    .dec_i (~bus.upd_taken),
    .cnt_o (up_cnt_nxt)
  );

`ifdef BP_BTB_EN
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             vld_q [ENTRIES];
  logic             vld_d [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [TAG_W-1:0] tag_d [ENTRIES];
  logic [31:0]      tgt_q [ENTRIES];
  logic [31:0]      tgt_d [ENTRIES];
  logic             lk_hit;

  assign lk_tag = TAG_W'(tag(bus.if_pc, IDX_W, TAG_W));
  assign up_tag = TAG_W'(tag(bus.upd_pc, IDX_W, TAG_W));
  assign lk_hit = ready & vld_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit & lk_cnt[CNT_W-1];
  assign bus.pred_target = lk_hit ? tgt_q[lk_idx] : 32'h0;
`else
  // Aliasing PCs share a counter; the real target is resolved in ID.
  logic unused_upd_target;
  assign unused_upd_target = ^bus.upd_target;

  assign bus.pred_hit    = ready;
  assign bus.pred_taken  = ready & lk_cnt[CNT_W-1];
  assign bus.pred_target = 32'h0;
`endif

  assign bus.ready         = ready;
  assign bus.stat_branches = stat_br_q;
  assign bus.stat_mispred  = stat_mp_q;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    cnt_d     = cnt_q;
`ifdef BP_BTB_EN
    vld_d     = vld_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        cnt_d[clr_idx_q] = CNT_INIT;
`ifdef BP_BTB_EN
        vld_d[clr_idx_q] = 1'b0;
`endif
        if (bus.flush) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == IDX_LAST) begin
          state_d   = ST_RUN;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        // A flush wins over an update presented in the same cycle.
        if (bus.flush) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else if (bus.upd_valid) begin
          cnt_d[up_idx] = up_cnt_nxt;
`ifdef BP_BTB_EN
          if (bus.upd_taken) begin
            vld_d[up_idx] = 1'b1;
            tag_d[up_idx] = up_tag;
            tgt_d[up_idx] = bus.upd_target;
          end
`endif
          if (stat_br_q != {STAT_W{1'b1}}) begin
            stat_br_d = stat_br_q + 1'b1;
          end
          if ((bus.upd_taken != bus.upd_pred_taken) && (stat_mp_q != {STAT_W{1'b1}})) begin
            stat_mp_d = stat_mp_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  // Table contents need no reset: the CLEAR walk initialises every entry.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
`ifdef BP_BTB_EN
    vld_q <= vld_d;
    tag_q <= tag_d;
    tgt_q <= tgt_d;
`endif
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_W=6, CNT_W=2, TAG_W=8, STAT_W=16).
module tb_branch_predictor;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  branch_predictor_if #(.STAT_W(16)) bp_bus ();

  branch_predictor #(
    .IDX_W  (6),
    .CNT_W  (2),
    .TAG_W  (8),
    .STAT_W (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bp_bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int exp_br   = 0;
  int exp_mp   = 0;
  int bad;

`ifdef BP_BTB_EN
  localparam logic BTB = 1'b1;
`else
  localparam logic BTB = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic pt,
                     input logic [31:0] tgt);
    bp_bus.upd_valid      = 1'b1;
    bp_bus.upd_pc         = pc;
    bp_bus.upd_taken      = taken;
    bp_bus.upd_pred_taken = pt;
    bp_bus.upd_target     = tgt;
    step();
    bp_bus.upd_valid = 1'b0;
    exp_br++;
    if (taken != pt) exp_mp++;
    #1;
  endtask

  initial begin
    reset_n               = 1'b0;
    bp_bus.flush          = 1'b0;
    bp_bus.if_pc          = 32'h10;
    bp_bus.upd_valid      = 1'b0;
    bp_bus.upd_pc         = 32'h0;
    bp_bus.upd_taken      = 1'b0;
    bp_bus.upd_target     = 32'h0;
    bp_bus.upd_pred_taken = 1'b0;
    #12;
    chk("rst_ready",  bp_bus.ready, 0);
    chk("rst_taken",  bp_bus.pred_taken, 0);
    chk("rst_hit",    bp_bus.pred_hit, 0);
    chk("rst_target", bp_bus.pred_target, 0);
    chk("rst_br",     bp_bus.stat_branches, 0);
    chk("rst_mp",     bp_bus.stat_mispred, 0);

    // 1. clear walk: 64 cycles of ready=0, then ready=1
    step();
    reset_n = 1'b1;
    #1;
    bad = 0;
    if (bp_bus.ready !== 1'b0 || bp_bus.pred_taken !== 1'b0) bad++;
    for (int i = 0; i < 63; i++) begin
      step();
      if (bp_bus.ready !== 1'b0 || bp_bus.pred_taken !== 1'b0) bad++;
    end
    chk("clear_low_cycles", bad, 0);
    step();
    chk("clear_done_ready", bp_bus.ready, 1);
    chk("clear_done_taken", bp_bus.pred_taken, 0);
    chk("clear_done_hit",   bp_bus.pred_hit, BTB ? 0 : 1);

    // 2. training 0x10: 01 -> 10 -> 11 -> 10 -> 01
    upd(32'h10, 1'b1, 1'b0, 32'h200);
    chk("train_t1", bp_bus.pred_taken, 1);
    upd(32'h10, 1'b1, 1'b1, 32'h200);
    chk("train_t2", bp_bus.pred_taken, 1);
    upd(32'h10, 1'b0, 1'b1, 32'h200);
    chk("train_n1", bp_bus.pred_taken, 1);
    upd(32'h10, 1'b0, 1'b1, 32'h200);
    chk("train_n2", bp_bus.pred_taken, 0);
    chk("train_br", bp_bus.stat_branches, exp_br);
    chk("train_mp", bp_bus.stat_mispred, exp_mp);

    // 3. alias 0x110 shares index 4 with 0x10; counter now 10
    upd(32'h10, 1'b1, 1'b0, 32'h200);
    bp_bus.if_pc = 32'h110;
    #1;
    chk("alias_taken", bp_bus.pred_taken, BTB ? 0 : 1);
    chk("alias_hit",   bp_bus.pred_hit, BTB ? 0 : 1);
    bp_bus.if_pc = 32'h10;
    #1;
    chk("own_target", bp_bus.pred_target, BTB ? 32'h200 : 32'h0);
    chk("own_taken",  bp_bus.pred_taken, 1);

    // 4. same-cycle lookup/update: old value now, new value next cycle
    upd(32'h10, 1'b0, 1'b0, 32'h200);
    chk("pre_same_taken", bp_bus.pred_taken, 0);
    bp_bus.upd_valid      = 1'b1;
    bp_bus.upd_pc         = 32'h10;
    bp_bus.upd_taken      = 1'b1;
    bp_bus.upd_pred_taken = 1'b0;
    bp_bus.upd_target     = 32'h200;
    #1;
    chk("same_cycle_old", bp_bus.pred_taken, 0);
    step();
    bp_bus.upd_valid = 1'b0;
    exp_br++;
    exp_mp++;
    #1;
    chk("same_cycle_new", bp_bus.pred_taken, 1);
    chk("same_br", bp_bus.stat_branches, exp_br);
    chk("same_mp", bp_bus.stat_mispred, exp_mp);

    // 5. flush with an update in the same cycle and during the clear walk
    bp_bus.flush          = 1'b1;
    bp_bus.upd_valid      = 1'b1;
    bp_bus.upd_pc         = 32'h10;
    bp_bus.upd_taken      = 1'b0;
    bp_bus.upd_pred_taken = 1'b1;
    step();
    bp_bus.flush = 1'b0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (bp_bus.ready !== 1'b0) bad++;
      step();
    end
    bp_bus.upd_valid = 1'b0;
    #1;
    chk("flush_low_cycles", bad, 0);
    chk("flush_ready",      bp_bus.ready, 1);
    chk("flush_br",         bp_bus.stat_branches, exp_br);
    chk("flush_mp",         bp_bus.stat_mispred, exp_mp);
    chk("flush_cnt_msb",    bp_bus.pred_taken, 0);
    chk("flush_hit",        bp_bus.pred_hit, BTB ? 0 : 1);
    upd(32'h10, 1'b1, 1'b0, 32'h300);
    chk("flush_cnt_01", bp_bus.pred_taken, 1);
    chk("flush_target", bp_bus.pred_target, BTB ? 32'h300 : 32'h0);

    // 6. saturating statistics, then async reset mid-stream
    bp_bus.upd_valid      = 1'b1;
    bp_bus.upd_pc         = 32'h20;
    bp_bus.upd_taken      = 1'b1;
    bp_bus.upd_pred_taken = 1'b0;
    repeat (65540) step();
    chk("sat_br", bp_bus.stat_branches, 32'hFFFF);
    chk("sat_mp", bp_bus.stat_mispred, 32'hFFFF);
    reset_n = 1'b0;
    #1;
    chk("midrst_br",    bp_bus.stat_branches, 0);
    chk("midrst_mp",    bp_bus.stat_mispred, 0);
    chk("midrst_ready", bp_bus.ready, 0);
    chk("midrst_taken", bp_bus.pred_taken, 0);
    bp_bus.upd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
